// File: rtl/cascade_counter_ctrl.sv
// rtl/cascade_counter_ctrl.sv - start/load/run sequencer around a cascade of 4-bit counter slices
// Optional macro CASCADE_PRESCALE_EN adds a per-run prescaler on the count enable.
module cascade_counter_ctrl #(
  parameter int SLICES = 2,
  localparam int WIDTH = 4 * SLICES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              periodic,
`ifdef CASCADE_PRESCALE_EN
  input  logic [3:0]        presc,
`endif
  input  logic              count_en,
  input  logic              stop,
  output logic [WIDTH-1:0]  cnt_q,
  output logic [SLICES-1:0] carry_chain,
  output logic              rco,
  output logic              tick,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_preset;
  logic               r_periodic;
  logic               w_adv;
  logic               w_tc;
  logic               w_en;
  logic [SLICES-1:0]  w_carry;
  logic [WIDTH-1:0]   w_cnt_inc;

`ifdef CASCADE_PRESCALE_EN
  logic [3:0] r_presc;
  logic [3:0] r_psc_cnt;

  assign w_adv = count_en & (r_state == S_RUN) & (r_psc_cnt == r_presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= 4'h0;
      r_psc_cnt <= 4'h0;
    end else begin
      if (r_state == S_IDLE && start_valid) begin
        r_presc <= presc;
      end
      if (r_state == S_LOAD) begin
        r_psc_cnt <= 4'h0;
      end else if (r_state == S_RUN) begin
        if (stop) begin
          r_psc_cnt <= 4'h0;
        end else if (count_en) begin
          r_psc_cnt <= (r_psc_cnt == r_presc) ? 4'h0 : r_psc_cnt + 4'h1;
        end
      end
    end
  end
`else
  assign w_adv = count_en & (r_state == S_RUN);
`endif

  // Each slice increments only when every lower slice is at 0xF (74163 ENT chaining).
  always_comb begin
    w_carry   = '0;
    w_cnt_inc = r_cnt;
    w_en      = w_adv;
    for (int k = 0; k < SLICES; k++) begin
      w_cnt_inc[4*k +: 4] = r_cnt[4*k +: 4] + {3'b000, w_en};
      w_carry[k]          = w_en & (r_cnt[4*k +: 4] == 4'hF);
      w_en                = w_carry[k];
    end
  end

  assign w_tc        = w_carry[SLICES-1];
  assign carry_chain = w_carry;
  assign rco         = w_carry[SLICES-1];
  assign tick        = w_tc & ~stop;
  assign start_ready = (r_state == S_IDLE);
  assign busy        = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign cnt_q       = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_valid) w_next = S_LOAD;
      S_LOAD: w_next = S_RUN;
      S_RUN: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (w_tc && !r_periodic) begin
          w_next = S_DONE;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_preset   <= '0;
      r_periodic <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_preset   <= load_val;
            r_periodic <= periodic;
          end
        end
        S_LOAD: r_cnt <= r_preset;
        S_RUN: begin
          if (!stop && w_adv) begin
            if (w_tc) begin
              if (r_periodic) r_cnt <= r_preset;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cascade_counter_ctrl.sv
// tb/tb_cascade_counter_ctrl.sv - directed scoreboard bench for cascade_counter_ctrl (SLICES=2)
module tb_cascade_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] load_val;
  logic       periodic;
`ifdef CASCADE_PRESCALE_EN
  logic [3:0] presc = 4'h0;
`endif
  logic       count_en;
  logic       stop;
  logic [7:0] cnt_q;
  logic [1:0] carry_chain;
  logic       rco;
  logic       tick;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tick;
    logic       rco;
    logic [1:0] carry;
    logic       done;
    logic       busy;
    logic       ready;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  cascade_counter_ctrl #(.SLICES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .load_val    (load_val),
    .periodic    (periodic),
`ifdef CASCADE_PRESCALE_EN
    .presc       (presc),
`endif
    .count_en    (count_en),
    .stop        (stop),
    .cnt_q       (cnt_q),
    .carry_chain (carry_chain),
    .rco         (rco),
    .tick        (tick),
    .busy        (busy),
    .done        (done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input string fld, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s %s: got %h expected %h", tag, fld, got, want);
    end
  endtask

  task automatic exp(input string tag, input logic [7:0] c, input logic t, input logic r,
                     input logic [1:0] cc, input logic d, input logic b, input logic rdy);
    exp_t e;
    exp_t g;
    string s;
    e = '{cnt: c, tick: t, rco: r, carry: cc, done: d, busy: b, ready: rdy};
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    g = sb_q.pop_front();
    s = tag_q.pop_front();
    cmp(s, "cnt_q", cnt_q, g.cnt);
    cmp(s, "tick", {7'd0, tick}, {7'd0, g.tick});
    cmp(s, "rco", {7'd0, rco}, {7'd0, g.rco});
    cmp(s, "carry_chain", {6'd0, carry_chain}, {6'd0, g.carry});
    cmp(s, "done", {7'd0, done}, {7'd0, g.done});
    cmp(s, "busy", {7'd0, busy}, {7'd0, g.busy});
    cmp(s, "start_ready", {7'd0, start_ready}, {7'd0, g.ready});
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b1; load_val = 8'h55; periodic = 1'b0;
    count_en = 1'b1; stop = 1'b0;

    // Reset with start_valid held: nothing accepted.
    cyc(); exp("rst1", 8'h00, 0, 0, 2'b00, 0, 0, 1);
    cyc(); exp("rst2", 8'h00, 0, 0, 2'b00, 0, 0, 1);
    rst = 1'b0; start_valid = 1'b0;
    cyc(); exp("rst_idle", 8'h00, 0, 0, 2'b00, 0, 0, 1);

    // One-shot FC..FF.
    load_val = 8'hFC; periodic = 1'b0; count_en = 1'b1; start_valid = 1'b1;
    cyc(); start_valid = 1'b0; load_val = 8'h00;
    exp("os_load", 8'h00, 0, 0, 2'b00, 0, 1, 0);
    cyc(); exp("os_fc", 8'hFC, 0, 0, 2'b00, 0, 1, 0);
    cyc(); exp("os_fd", 8'hFD, 0, 0, 2'b00, 0, 1, 0);
    cyc(); exp("os_fe", 8'hFE, 0, 0, 2'b00, 0, 1, 0);
    cyc(); exp("os_ff", 8'hFF, 1, 1, 2'b11, 0, 1, 0);
    cyc(); exp("os_done", 8'hFF, 0, 0, 2'b00, 1, 0, 0);
    cyc(); exp("os_idle", 8'hFF, 0, 0, 2'b00, 0, 0, 1);

    // Periodic FE/FF reload, then stop.
    load_val = 8'hFE; periodic = 1'b1; start_valid = 1'b1;
    cyc(); start_valid = 1'b0; load_val = 8'h11; periodic = 1'b0;
    exp("per_load", 8'hFF, 0, 0, 2'b00, 0, 1, 0);
    cyc(); exp("per_fe0", 8'hFE, 0, 0, 2'b00, 0, 1, 0);
    cyc(); exp("per_ff0", 8'hFF, 1, 1, 2'b11, 0, 1, 0);
    cyc(); exp("per_fe1", 8'hFE, 0, 0, 2'b00, 0, 1, 0);
    cyc(); exp("per_ff1", 8'hFF, 1, 1, 2'b11, 0, 1, 0);
    cyc(); stop = 1'b1;
    exp("per_stop", 8'hFE, 0, 0, 2'b00, 0, 1, 0);
    cyc(); stop = 1'b0;
    exp("per_idle", 8'hFE, 0, 0, 2'b00, 0, 0, 1);
    cyc(); exp("per_frozen", 8'hFE, 0, 0, 2'b00, 0, 0, 1);

    // Slice carry with count_en 1,0,1.
    load_val = 8'h0E; periodic = 1'b0; count_en = 1'b1; start_valid = 1'b1;
    cyc(); start_valid = 1'b0;
    cyc(); exp("sc_0e", 8'h0E, 0, 0, 2'b00, 0, 1, 0);
    cyc(); count_en = 1'b0;
    exp("sc_0f_off", 8'h0F, 0, 0, 2'b00, 0, 1, 0);
    cyc(); count_en = 1'b1;
    exp("sc_0f_on", 8'h0F, 0, 0, 2'b01, 0, 1, 0);
    cyc(); exp("sc_10", 8'h10, 0, 0, 2'b00, 0, 1, 0);
    stop = 1'b1;
    cyc(); stop = 1'b0;
    exp("sc_idle", 8'h10, 0, 0, 2'b00, 0, 0, 1);

    // Stop wins over terminal count.
    load_val = 8'hFF; periodic = 1'b0; start_valid = 1'b1;
    cyc(); start_valid = 1'b0;
    cyc(); stop = 1'b1;
    exp("st_ff", 8'hFF, 0, 1, 2'b11, 0, 1, 0);
    cyc(); stop = 1'b0;
    exp("st_idle", 8'hFF, 0, 0, 2'b00, 0, 0, 1);
    cyc(); exp("st_nodone", 8'hFF, 0, 0, 2'b00, 0, 0, 1);

    // Reset mid-RUN, then restart.
    load_val = 8'h30; start_valid = 1'b1;
    cyc(); start_valid = 1'b0;
    cyc(); exp("mr_30", 8'h30, 0, 0, 2'b00, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc();
    exp("mr_35", 8'h35, 0, 0, 2'b00, 0, 1, 0);
    rst = 1'b1;
    cyc(); rst = 1'b0;
    exp("mr_rst", 8'h00, 0, 0, 2'b00, 0, 0, 1);
    load_val = 8'h80; start_valid = 1'b1;
    cyc(); start_valid = 1'b0;
    exp("mr_load", 8'h00, 0, 0, 2'b00, 0, 1, 0);
    cyc(); exp("mr_80", 8'h80, 0, 0, 2'b00, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
